// File: rtl/axi_mem_slave.sv
// Single-port BRAM-backed AXI4 slave memory serving one INCR burst of 32-bit beats at a time.
// Reads flow through the synchronous RAM register (prefetch stage) into a held output register.
module axi_mem_slave #(
    parameter int    AXI_ADDR_WIDTH = 64,
    parameter int    AXI_DATA_WIDTH = 32,
    parameter int    MEM_DEPTH      = 4096,
    parameter string INIT_FILE      = ""
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        AW_VALID,
    output logic                        AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
    input  logic [7:0]                  AW_LEN,
    input  logic [2:0]                  AW_SIZE,
    input  logic [1:0]                  AW_BURST,
    input  logic [2:0]                  AW_PROT,
    input  logic                        W_VALID,
    output logic                        W_READY,
    input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
    input  logic                        W_LAST,
    output logic                        B_VALID,
    input  logic                        B_READY,
    output logic [1:0]                  B_RESP,
    input  logic                        AR_VALID,
    output logic                        AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
    input  logic [7:0]                  AR_LEN,
    input  logic [2:0]                  AR_SIZE,
    input  logic [1:0]                  AR_BURST,
    input  logic [2:0]                  AR_PROT,
    output logic                        R_VALID,
    input  logic                        R_READY,
    output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
    output logic [1:0]                  R_RESP,
    output logic                        R_LAST
);

    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam int NB   = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_WR      = 2'd2,
        S_WR_RESP = 2'd3
    } state_t;

    function automatic logic burst_err(input logic [1:0] addr_lo, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (addr_lo != 2'b00) || (size != 3'b010) || (burst != 2'b01);
    endfunction

    // A zero length field still moves one beat.
    function automatic logic [7:0] beat_count(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

    state_t                    r_state;
    logic                      r_arready;
    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic                      r_rlast;
    logic                      r_pf_valid;
    logic                      r_err;
    logic [7:0]                r_count;
    logic [7:0]                r_issue_cnt;
    logic [7:0]                r_beat_cnt;
    logic [IDXW-1:0]           r_idx;
    logic [AXI_DATA_WIDTH-1:0] r_ram_q;
    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic            w_ar_hs;
    logic            w_aw_hs;
    logic            w_out_load;
    logic            w_rd_take;
    logic            w_issue_rd;
    logic            w_w_hs;
    logic            w_w_done;
    logic            w_rd_en;
    logic            w_we;
    logic [IDXW-1:0] w_rd_idx;
    logic            w_unused;

    assign w_unused = ^{AW_PROT, AR_PROT, AW_ADDR[AXI_ADDR_WIDTH-1:IDXW+2],
                        AR_ADDR[AXI_ADDR_WIDTH-1:IDXW+2]};

    assign w_ar_hs    = (r_state == S_IDLE) && r_arready && AR_VALID;
    assign w_aw_hs    = (r_state == S_IDLE) && r_awready && AW_VALID && !AR_VALID;
    assign w_rd_take  = r_rvalid && R_READY;
    assign w_out_load = (r_state == S_RD) && r_pf_valid && (!r_rvalid || R_READY);
    assign w_issue_rd = (r_state == S_RD) && (r_issue_cnt != r_count) && (!r_pf_valid || w_out_load);
    assign w_w_hs     = (r_state == S_WR) && r_wready && W_VALID;
    assign w_w_done   = W_LAST || (r_beat_cnt == (r_count - 8'd1));

    // RAM port control: the first read word is fetched in the AR handshake cycle itself.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_idx = r_idx;
        w_we     = arstn && w_w_hs && !r_err;
        if (!arstn) begin
            w_rd_en = 1'b0;
        end else if (w_ar_hs) begin
            w_rd_en  = 1'b1;
            w_rd_idx = AR_ADDR[IDXW+1:2];
        end else if (w_issue_rd) begin
            w_rd_en = 1'b1;
        end else begin
            w_rd_en = 1'b0;
        end
    end

    // Memory array with byte-enabled writes and a registered read port; never reset.
    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_idx];
        end
        if (w_we) begin
            for (int b = 0; b < NB; b++) begin
                if (W_STRB[b]) begin
                    r_mem[r_idx][8*b +: 8] <= W_DATA[8*b +: 8];
                end
            end
        end
    end

    // Burst control FSM with all AXI outputs registered.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state     <= S_IDLE;
            r_arready   <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_rvalid    <= 1'b0;
            r_rdata     <= {AXI_DATA_WIDTH{1'b0}};
            r_rresp     <= 2'b00;
            r_rlast     <= 1'b0;
            r_pf_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= 8'd0;
            r_issue_cnt <= 8'd0;
            r_beat_cnt  <= 8'd0;
            r_idx       <= {IDXW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_state     <= S_RD;
                        r_arready   <= 1'b0;
                        r_awready   <= 1'b0;
                        r_idx       <= AR_ADDR[IDXW+1:2] + 1'b1;
                        r_count     <= beat_count(AR_LEN);
                        r_err       <= burst_err(AR_ADDR[1:0], AR_SIZE, AR_BURST);
                        r_issue_cnt <= 8'd1;
                        r_beat_cnt  <= 8'd0;
                        r_pf_valid  <= 1'b1;
                    end else if (w_aw_hs) begin
                        r_state    <= S_WR;
                        r_arready  <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_idx      <= AW_ADDR[IDXW+1:2];
                        r_count    <= beat_count(AW_LEN);
                        r_err      <= burst_err(AW_ADDR[1:0], AW_SIZE, AW_BURST);
                        r_beat_cnt <= 8'd0;
                    end else begin
                        r_arready <= 1'b1;
                        r_awready <= 1'b1;
                    end
                end
                S_RD: begin
                    if (w_issue_rd) begin
                        r_idx       <= r_idx + 1'b1;
                        r_issue_cnt <= r_issue_cnt + 8'd1;
                        r_pf_valid  <= 1'b1;
                    end else if (w_out_load) begin
                        r_pf_valid <= 1'b0;
                    end
                    // A new beat may replace the one being accepted in the same cycle.
                    if (w_out_load) begin
                        r_rvalid   <= 1'b1;
                        r_rdata    <= r_err ? {AXI_DATA_WIDTH{1'b0}} : r_ram_q;
                        r_rresp    <= r_err ? 2'b10 : 2'b00;
                        r_rlast    <= (r_beat_cnt == (r_count - 8'd1));
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end else if (w_rd_take) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_state   <= S_IDLE;
                            r_arready <= 1'b1;
                            r_awready <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (w_w_hs) begin
                        r_idx      <= r_idx + 1'b1;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_w_done) begin
                            r_state  <= S_WR_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= r_err ? 2'b10 : 2'b00;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (B_READY) begin
                        r_bvalid  <= 1'b0;
                        r_state   <= S_IDLE;
                        r_arready <= 1'b1;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign AR_READY = r_arready;
    assign AW_READY = r_awready;
    assign W_READY  = r_wready;
    assign B_VALID  = r_bvalid;
    assign B_RESP   = r_bresp;
    assign R_VALID  = r_rvalid;
    assign R_DATA   = r_rdata;
    assign R_RESP   = r_rresp;
    assign R_LAST   = r_rlast;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected read beats are queued when a read is issued
// and popped as the slave hands them over; a byte-level memory model tracks writes.
module tb_axi_mem_slave;
    localparam int AWID  = 64;
    localparam int DEPTH = 4096;
    localparam int TMO   = 300;

    logic            clk = 1'b0;
    logic            arstn;
    logic            AW_VALID, AW_READY;
    logic [AWID-1:0] AW_ADDR;
    logic [7:0]      AW_LEN;
    logic [2:0]      AW_SIZE, AW_PROT;
    logic [1:0]      AW_BURST;
    logic            W_VALID, W_READY, W_LAST;
    logic [31:0]     W_DATA;
    logic [3:0]      W_STRB;
    logic            B_VALID, B_READY;
    logic [1:0]      B_RESP;
    logic            AR_VALID, AR_READY;
    logic [AWID-1:0] AR_ADDR;
    logic [7:0]      AR_LEN;
    logic [2:0]      AR_SIZE, AR_PROT;
    logic [1:0]      AR_BURST;
    logic            R_VALID, R_READY, R_LAST;
    logic [31:0]     R_DATA;
    logic [1:0]      R_RESP;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] mdl [DEPTH];
    logic [34:0] exp_q [$];

    always #5 clk = ~clk;

    axi_mem_slave #(
        .AXI_ADDR_WIDTH(AWID), .AXI_DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .INIT_FILE("")
    ) u_dut (
        .clk(clk), .arstn(arstn),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
        .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST), .AW_PROT(AW_PROT),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN),
        .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_PROT(AR_PROT),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_err(input logic [AWID-1:0] a, input logic [2:0] s, input logic [1:0] b);
        return (a[1:0] != 2'b00) || (s != 3'b010) || (b != 2'b01);
    endfunction

    function automatic int beats(input logic [7:0] len);
        return (len == 8'd0) ? 1 : int'(len);
    endfunction

    function automatic int widx(input logic [AWID-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic wr_burst(input logic [AWID-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [31:0] base, input logic [3:0] strb);
        int   n, idx, cyc;
        logic err;
        n   = beats(len);
        idx = widx(addr);
        err = is_err(addr, size, 2'b01);
        AW_ADDR = addr; AW_LEN = len; AW_SIZE = size; AW_BURST = 2'b01; AW_VALID = 1'b1;
        cyc = 0;
        while (!AW_READY && cyc < TMO) begin tick; cyc++; end
        if (!AW_READY) begin
            check_val("aw_tmo", AW_READY, 1);
            AW_VALID = 1'b0;
            return;
        end
        tick;
        AW_VALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            W_VALID = 1'b1; W_DATA = base + 32'(i); W_STRB = strb; W_LAST = (i == n - 1);
            cyc = 0;
            while (!W_READY && cyc < TMO) begin tick; cyc++; end
            if (!W_READY) begin
                check_val("w_tmo", W_READY, 1);
                break;
            end
            tick;
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mdl[idx][8*b +: 8] = W_DATA[8*b +: 8];
                end
            end
            idx = (idx + 1) % DEPTH;
        end
        W_VALID = 1'b0; W_LAST = 1'b0;
        check_val("b_valid", B_VALID, 1);
        check_val("b_resp", B_RESP, err ? 2'b10 : 2'b00);
        check_val("w_ready_off", W_READY, 0);
        B_READY = 1'b1;
        tick;
        B_READY = 1'b0;
        check_val("b_clear", B_VALID, 0);
        check_val("aw_ready_back", AW_READY, 1);
    endtask

    task automatic rd_burst(input logic [AWID-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic toggle, input int abort_at, input logic aw_watch);
        int          n, idx, cyc, got;
        logic        err, held_v;
        logic [35:0] held;
        logic [34:0] e;
        n   = beats(len);
        idx = widx(addr);
        err = is_err(addr, size, 2'b01);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({err ? 2'b10 : 2'b00, (i == n - 1) ? 1'b1 : 1'b0, err ? 32'h0 : mdl[idx]});
            idx = (idx + 1) % DEPTH;
        end
        AR_ADDR = addr; AR_LEN = len; AR_SIZE = size; AR_BURST = 2'b01; AR_VALID = 1'b1;
        cyc = 0;
        while (!AR_READY && cyc < TMO) begin tick; cyc++; end
        if (!AR_READY) begin
            check_val("ar_tmo", AR_READY, 1);
            AR_VALID = 1'b0;
            return;
        end
        tick;
        AR_VALID = 1'b0;
        check_val("r_lat_c1", R_VALID, 0);
        tick;
        check_val("r_lat_c2", R_VALID, 1);
        got = 0; cyc = 0; held_v = 1'b0; held = 36'h0;
        while (got < n && cyc < TMO && !(abort_at >= 0 && got == abort_at)) begin
            if (aw_watch) check_val("aw_blocked", AW_READY, 0);
            if (held_v) check_val("r_hold", {R_VALID, R_LAST, R_RESP, R_DATA}, held);
            R_READY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (R_VALID && R_READY) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underrun", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("r_data", R_DATA, e[31:0]);
                    check_val("r_resp", R_RESP, e[34:33]);
                    check_val("r_last", R_LAST, e[32]);
                end
                got++;
                held_v = 1'b0;
            end else begin
                held_v = R_VALID;
                held   = {R_VALID, R_LAST, R_RESP, R_DATA};
            end
            tick;
            cyc++;
        end
        R_READY = 1'b0;
        if (abort_at < 0) begin
            check_val("r_beats", got, n);
            if (!toggle) check_val("r_thruput", cyc, n);
            check_val("r_valid_off", R_VALID, 0);
            check_val("ar_ready_back", AR_READY, 1);
        end
    endtask

    initial begin
        arstn = 1'b0;
        AW_VALID = 1'b0; AW_ADDR = '0; AW_LEN = 8'd0; AW_SIZE = 3'b010; AW_BURST = 2'b01; AW_PROT = 3'b000;
        W_VALID = 1'b0; W_DATA = 32'h0; W_STRB = 4'h0; W_LAST = 1'b0; B_READY = 1'b0;
        AR_VALID = 1'b0; AR_ADDR = '0; AR_LEN = 8'd0; AR_SIZE = 3'b010; AR_BURST = 2'b01; AR_PROT = 3'b000;
        R_READY = 1'b0;

        // Reset: every output low, readies up in the first cycle after release.
        tick; tick;
        check_val("rst_outs", {AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP, R_LAST}, 64'd0);
        arstn = 1'b1;
        tick;
        check_val("rst_ar_ready", AR_READY, 1);
        check_val("rst_aw_ready", AW_READY, 1);

        // Full-line write then read back, continuous and with a stalling master.
        wr_burst(64'h100, 8'd16, 3'b010, 32'hA0, 4'hF);
        rd_burst(64'h100, 8'd16, 3'b010, 1'b0, -1, 1'b0);
        rd_burst(64'h100, 8'd16, 3'b010, 1'b1, -1, 1'b0);

        // Length zero moves a single beat.
        rd_burst(64'h104, 8'd0, 3'b010, 1'b0, -1, 1'b0);

        // Bad size: write suppressed with SLVERR, memory still holds the line.
        wr_burst(64'h100, 8'd2, 3'b011, 32'hDEAD0000, 4'hF);
        rd_burst(64'h100, 8'd2, 3'b010, 1'b0, -1, 1'b0);

        // Simultaneous AR/AW: read wins, write waits until the read completes.
        AW_ADDR = 64'h200; AW_LEN = 8'd2; AW_SIZE = 3'b010; AW_BURST = 2'b01; AW_VALID = 1'b1;
        rd_burst(64'h100, 8'd16, 3'b010, 1'b0, -1, 1'b1);
        wr_burst(64'h200, 8'd2, 3'b010, 32'h12345670, 4'hF);
        rd_burst(64'h200, 8'd2, 3'b010, 1'b1, -1, 1'b0);

        // Wrap across the top of memory, then a byte-0-only overwrite.
        wr_burst(64'((DEPTH - 2) * 4), 8'd4, 3'b010, 32'h5A5A0000, 4'hF);
        wr_burst(64'((DEPTH - 2) * 4), 8'd4, 3'b010, 32'hC3C3C3C0, 4'b0001);
        rd_burst(64'((DEPTH - 2) * 4), 8'd4, 3'b010, 1'b0, -1, 1'b0);
        rd_burst(64'h0, 8'd2, 3'b010, 1'b0, -1, 1'b0);

        // Unaligned read returns zero/SLVERR; reset part-way abandons the burst.
        rd_burst(64'h102, 8'd16, 3'b010, 1'b0, 5, 1'b0);
        arstn = 1'b0;
        tick;
        check_val("abort_r_valid", R_VALID, 0);
        check_val("abort_ar_ready", AR_READY, 0);
        exp_q.delete();
        arstn = 1'b1;
        tick;
        check_val("abort_idle", AR_READY, 1);
        check_val("abort_no_beat", R_VALID, 0);
        rd_burst(64'h100, 8'd16, 3'b010, 1'b1, -1, 1'b0);

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
